// File: rtl/sprite_cmd_pkg.sv
// Shared types and encodings for the sprite command bus encoder.
// Both the FIFO and the word formatter use the record layout and word helpers below.
package sprite_cmd_pkg;

  localparam logic [3:0] INFO_NOP   = 4'h0;
  localparam logic [3:0] INFO_WRITE = 4'h1;
  localparam logic [3:0] INFO_FLUSH = 4'hF;

  localparam logic [2:0] TYPE_ATTR  = 3'b001;
  localparam logic [2:0] TYPE_X     = 3'b010;
  localparam logic [2:0] TYPE_Y     = 3'b011;
  localparam logic [2:0] TYPE_SHIFT = 3'b100;

  typedef struct packed {
    logic [5:0] sub_comp;
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } sprite_upd_t;

  typedef struct packed {
    logic [5:0]  sub_comp;
    logic [4:0]  child;
    logic [3:0]  info;
    logic [2:0]  typ;
    logic        pp_selc;
    logic [12:0] msg;
  } cmd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTR,
    ST_X,
    ST_Y,
    ST_SHIFT,
    ST_FLUSH
  } enc_state_e;

  function automatic cmd_word_t write_word(input sprite_upd_t rec, input logic [2:0] typ,
                                           input logic pp);
    cmd_word_t w;
    w.sub_comp = rec.sub_comp;
    w.child    = rec.child;
    w.info     = INFO_WRITE;
    w.typ      = typ;
    w.pp_selc  = pp;
    case (typ)
      TYPE_ATTR:  w.msg = {rec.visible, rec.flip, 6'b0, rec.pattern};
      TYPE_X:     w.msg = {3'b0, rec.x};
      TYPE_Y:     w.msg = {3'b0, rec.y};
      TYPE_SHIFT: w.msg = {3'b0, rec.shift};
      default:    w.msg = '0;
    endcase
    return w;
  endfunction

  function automatic cmd_word_t flush_word(input logic pp);
    cmd_word_t w;
    w         = '0;
    w.info    = INFO_FLUSH;
    w.pp_selc = pp;
    return w;
  endfunction

endpackage

// File: rtl/sprite_upd_fifo.sv
// Synchronous FIFO of sprite update records with registered full/empty flags.
// Full and empty come from the next-state count, so both are plain flops at the outputs.
module sprite_upd_fifo
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  sprite_upd_t data_i,
  input  logic        pop_i,
  output sprite_upd_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sprite_upd_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Serializes queued sprite updates into 32-bit command words for the back buffer,
// and inserts one buffer-swap flush word per frame boundary between record groups.
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [5:0]  upd_sub_comp,
  input  logic [4:0]  upd_child,
  input  logic        upd_visible,
  input  logic        upd_flip,
  input  logic [4:0]  upd_pattern,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [9:0]  upd_shift,
  input  logic        frame_start,
  output logic [31:0] writedata,
  output logic        front_buf,
  output logic        busy
);

  enc_state_e  state_q, state_d;
  cmd_word_t   word_q, word_d;
  sprite_upd_t cur_q, cur_d;
  sprite_upd_t upd_rec, fifo_head;
  logic        front_buf_q, front_buf_d;
  logic        flush_pend_q, flush_pend_d;
  logic        fifo_full, fifo_empty, pop, take_flush;

  assign upd_rec = {upd_sub_comp, upd_child, upd_visible, upd_flip, upd_pattern,
                    upd_x, upd_y, upd_shift};

  sprite_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (upd_valid),
    .data_i  (upd_rec),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Each state's word is formed on the transition into it, so words leave back-to-back
  // and every idle cycle drives an all-zero no-op word.
  always_comb begin
    state_d     = state_q;
    word_d      = '0;
    cur_d       = cur_q;
    front_buf_d = front_buf_q;
    pop         = 1'b0;
    take_flush  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_pend_q) begin
          state_d     = ST_FLUSH;
          take_flush  = 1'b1;
          word_d      = flush_word(~front_buf_q);
          front_buf_d = ~front_buf_q;
        end else if (!fifo_empty) begin
          state_d = ST_ATTR;
          pop     = 1'b1;
          cur_d   = fifo_head;
          word_d  = write_word(fifo_head, TYPE_ATTR, ~front_buf_q);
        end
      end
      ST_ATTR: begin
        state_d = ST_X;
        word_d  = write_word(cur_q, TYPE_X, ~front_buf_q);
      end
      ST_X: begin
        state_d = ST_Y;
        word_d  = write_word(cur_q, TYPE_Y, ~front_buf_q);
      end
      ST_Y: begin
        state_d = ST_SHIFT;
        word_d  = write_word(cur_q, TYPE_SHIFT, ~front_buf_q);
      end
      ST_SHIFT: state_d = ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A pulse arriving while a flush is still owed (including the cycle it is taken) merges.
  assign flush_pend_d = take_flush ? 1'b0 : (flush_pend_q | frame_start);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      cur_q        <= '0;
      front_buf_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      cur_q        <= cur_d;
      front_buf_q  <= front_buf_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign upd_ready = ~fifo_full;
  assign writedata = word_q;
  assign front_buf = front_buf_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty | flush_pend_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Directed and randomized checks of the sprite command encoder against a
// stream-level model: accepted records in order, one flush per owed frame boundary.
module tb_sprite_cmd_encoder;

  typedef struct packed {
    logic [5:0] sub;
    logic [4:0] child;
    logic       vis;
    logic       flip;
    logic [4:0] pat;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] sh;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid, upd_ready;
  logic [5:0]  upd_sub_comp;
  logic [4:0]  upd_child;
  logic        upd_visible, upd_flip;
  logic [4:0]  upd_pattern;
  logic [9:0]  upd_x, upd_y, upd_shift;
  logic        frame_start;
  logic [31:0] writedata;
  logic        front_buf, busy;

  int   compared = 0;
  int   mismatched = 0;
  rec_t recQ[$];
  rec_t curRec;
  int   groupPos = 0;
  bit   mFront = 1'b0;
  bit   owed = 1'b0;
  int   acceptedTotal = 0;
  int   writeWords = 0;

  always #5 clk = ~clk;

  sprite_cmd_encoder #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_sub_comp (upd_sub_comp),
    .upd_child    (upd_child),
    .upd_visible  (upd_visible),
    .upd_flip     (upd_flip),
    .upd_pattern  (upd_pattern),
    .upd_x        (upd_x),
    .upd_y        (upd_y),
    .upd_shift    (upd_shift),
    .frame_start  (frame_start),
    .writedata    (writedata),
    .front_buf    (front_buf),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expWord(input rec_t r, input int pos, input bit front);
    logic [31:0] w;
    w = (32'(r.sub) << 26) + (32'(r.child) << 21) + (32'd1 << 17) + (32'(!front) << 13);
    case (pos)
      0:       w = w + (32'd1 << 14) + (32'(r.vis) << 12) + (32'(r.flip) << 11) + 32'(r.pat);
      1:       w = w + (32'd2 << 14) + 32'(r.x);
      2:       w = w + (32'd3 << 14) + 32'(r.y);
      default: w = w + (32'd4 << 14) + 32'(r.sh);
    endcase
    return w;
  endfunction

  function automatic logic [31:0] flushWord(input bit front);
    return (32'd15 << 17) + (32'(!front) << 13);
  endfunction

  function automatic rec_t randRec();
    rec_t r;
    r.sub   = 6'($urandom);
    r.child = 5'($urandom);
    r.vis   = 1'($urandom);
    r.flip  = 1'($urandom);
    r.pat   = 5'($urandom);
    r.x     = 10'($urandom);
    r.y     = 10'($urandom);
    r.sh    = 10'($urandom);
    return r;
  endfunction

  task automatic applyStimulus(input rec_t r, input logic v, input logic fs);
    upd_valid    = v;
    upd_sub_comp = r.sub;
    upd_child    = r.child;
    upd_visible  = r.vis;
    upd_flip     = r.flip;
    upd_pattern  = r.pat;
    upd_x        = r.x;
    upd_y        = r.y;
    upd_shift    = r.sh;
    frame_start  = fs;
  endtask

  task automatic waitWord(input string tag, input logic [31:0] expected);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (writedata == 32'h0 && n < 12);
    checkOutput(tag, writedata, expected);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    checkOutput(tag, 32'(busy), 32'd0);
    #1;
    checkOutput({tag, "_queue_empty"}, 32'(recQ.size()), 32'd0);
    checkOutput({tag, "_group_complete"}, 32'(groupPos), 32'd0);
    checkOutput({tag, "_no_flush_owed"}, 32'(owed), 32'd0);
  endtask

  // Acceptance and frame pulses are taken from the same edge the DUT samples.
  always @(posedge clk) begin
    if (reset) begin
      if (upd_valid && upd_ready) begin
        recQ.push_back({upd_sub_comp, upd_child, upd_visible, upd_flip, upd_pattern,
                        upd_x, upd_y, upd_shift});
        acceptedTotal++;
      end
      if (frame_start) owed = 1'b1;
    end
  end

  // Every nonzero word must be either the owed flush at a group boundary or the
  // next word of the oldest accepted record, aimed at the current back buffer.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!reset) begin
      recQ.delete();
      groupPos = 0;
      mFront   = 1'b0;
      owed     = 1'b0;
    end else begin
      w = writedata;
      if (w != 32'h0) begin
        if (w[20:17] == 4'hF) begin
          checkOutput("flush_owed", 32'(owed), 32'd1);
          checkOutput("flush_at_group_boundary", 32'(groupPos), 32'd0);
          checkOutput("flush_word", w, flushWord(mFront));
          mFront = !mFront;
          owed   = 1'b0;
        end else begin
          if (groupPos == 0) begin
            checkOutput("word_has_record", 32'(recQ.size() > 0), 32'd1);
            if (recQ.size() > 0) curRec = recQ.pop_front();
          end
          checkOutput("write_word", w, expWord(curRec, groupPos, mFront));
          groupPos = (groupPos + 1) % 4;
          writeWords++;
        end
      end
      checkOutput("front_buf", 32'(front_buf), 32'(mFront));
      checkOutput("upd_ready", 32'(upd_ready), 32'(recQ.size() < 4));
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rec_t r, idle;
    rec_t burst [8];
    int   i, startAcc, startWords, cnt;
    bit   sawFull;

    idle  = '0;
    reset = 1'b0;
    applyStimulus(idle, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_writedata", writedata, 32'h0);
    checkOutput("reset_front_buf", 32'(front_buf), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(upd_ready), 32'd1);
    #2 reset = 1'b1;

    // Single record with exact latency and word values.
    r = '{sub: 6'd1, child: 5'd2, vis: 1'b1, flip: 1'b0, pat: 5'd7,
          x: 10'd100, y: 10'd200, sh: 10'd5};
    @(negedge clk);
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    checkOutput("latency_gap", writedata, 32'h0);
    @(negedge clk); checkOutput("t1_attr", writedata, 32'h0442_7007);
    @(negedge clk); checkOutput("t1_x", writedata, 32'h0442_A064);
    @(negedge clk); checkOutput("t1_y", writedata, 32'h0442_E0C8);
    @(negedge clk); checkOutput("t1_shift", writedata, 32'h0443_2005);
    @(negedge clk); checkOutput("t1_zero_after", writedata, 32'h0);

    // Flush while idle, then a record lands in buffer 0.
    applyStimulus(idle, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t2_flush", 32'h001E_2000);
    checkOutput("t2_front_after_flush", 32'(front_buf), 32'd1);
    r = randRec();
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t2_attr", expWord(r, 0, 1'b1));
    checkOutput("t2_pp_bit", 32'(writedata[13]), 32'd0);
    repeat (4) @(negedge clk);

    // Frame pulse during the attr word: group completes, then the flush.
    r = randRec();
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t3_attr", expWord(r, 0, 1'b1));
    applyStimulus(idle, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    checkOutput("t3_x", writedata, expWord(r, 1, 1'b1));
    @(negedge clk); checkOutput("t3_y", writedata, expWord(r, 2, 1'b1));
    @(negedge clk); checkOutput("t3_shift", writedata, expWord(r, 3, 1'b1));
    waitWord("t3_flush", 32'h001E_0000);
    checkOutput("t3_front", 32'(front_buf), 32'd0);

    // Two pulses two cycles apart during one group produce a single flush.
    r = randRec();
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t4_attr", expWord(r, 0, 1'b0));
    applyStimulus(idle, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    checkOutput("t4_x", writedata, expWord(r, 1, 1'b0));
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b1);
    checkOutput("t4_y", writedata, expWord(r, 2, 1'b0));
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    checkOutput("t4_shift", writedata, expWord(r, 3, 1'b0));
    waitWord("t4_flush", 32'h001E_2000);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (writedata != 32'h0) cnt++;
    end
    checkOutput("t4_single_flush", 32'(cnt), 32'd0);

    // Eight records offered back-to-back into a four-deep queue.
    foreach (burst[k]) burst[k] = randRec();
    startAcc   = acceptedTotal;
    startWords = writeWords;
    sawFull    = 1'b0;
    i          = 0;
    applyStimulus(burst[0], 1'b1, 1'b0);
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (!upd_ready) sawFull = 1'b1;
      i = acceptedTotal - startAcc;
      if (i >= 8) begin
        applyStimulus(idle, 1'b0, 1'b0);
        break;
      end
      applyStimulus(burst[i], 1'b1, 1'b0);
    end
    checkOutput("t5_all_accepted", 32'(i), 32'd8);
    checkOutput("t5_ready_dropped", 32'(sawFull), 32'd1);
    waitIdle("t5_drain");
    checkOutput("t5_word_count", 32'(writeWords - startWords), 32'd32);

    // Randomized traffic with occasional frame pulses.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      applyStimulus(randRec(), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitIdle("rand_drain");

    // Reset during the y word aborts the group.
    r = randRec();
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t6_attr", expWord(r, 0, mFront));
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_at_y_word", 32'(writedata[16:14]), 32'd3);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_writedata", writedata, 32'h0);
    checkOutput("t6_front_buf", 32'(front_buf), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    #2 reset = 1'b1;
    r = randRec();
    @(negedge clk);
    applyStimulus(r, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(idle, 1'b0, 1'b0);
    waitWord("t6_post_reset_attr", expWord(r, 0, 1'b0));
    waitIdle("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
